game_sequencer: RTL and testbench

Top-level Tetris game-flow controller. It sequences the active piece through spawn, gravity fall, lock and line clear, using a probe handshake with the fallen-blocks/collision datapath. It keeps score and line count and drives the game-over state. It sits beside the rectangle controller, which owns xpos and rotation: this block owns ypos, piece type and lock timing. Outputs feed the piece-drawing and fallen-blocks stages.

---
 rtl/game_if.sv | 22 ++
 rtl/game_sequencer.sv | 142 ++++++++++++++
 tb/tb_game_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_if.sv
// Probe and line-clear handshake between the game sequencer and the
// fallen-blocks/collision datapath.
interface game_if;
  logic       probe_valid;
  logic [4:0] probe_y;
  logic       probe_done;
  logic       probe_hit;
  logic       lock_en;
  logic       clear_start;
  logic       clear_done;
  logic [2:0] lines_cleared;

  modport master (
    output probe_valid, probe_y, lock_en, clear_start,
    input  probe_done, probe_hit, clear_done, lines_cleared
  );

  modport slave (
    input  probe_valid, probe_y, lock_en, clear_start,
    output probe_done, probe_hit, clear_done, lines_cleared
  );
endinterface

// File: rtl/game_sequencer.sv
// Tetris game-flow controller: spawn, gravity fall, lock, line clear, scoring
// and game-over, talking to the collision datapath through game_if.
module game_sequencer #(
  parameter int         GRAV_TICKS = 37500000,
  parameter int         SOFT_TICKS = 3750000,
  parameter int         BOTTOM_ROW = 19,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        soft_drop,
  game_if.master      bus,
  output logic [4:0]  ypos,
  output logic [2:0]  block,
  output logic        piece_active,
  output logic [15:0] score,
  output logic [9:0]  lines_total,
  output logic        game_over
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_SPAWN      = 4'd1;
  localparam logic [3:0] S_SPAWN_CHK  = 4'd2;
  localparam logic [3:0] S_FALL       = 4'd3;
  localparam logic [3:0] S_PROBE      = 4'd4;
  localparam logic [3:0] S_LOCK       = 4'd5;
  localparam logic [3:0] S_CLEAR      = 4'd6;
  localparam logic [3:0] S_CLEAR_WAIT = 4'd7;
  localparam logic [3:0] S_GAME_OVER  = 4'd8;

  localparam int CNT_W = $clog2(GRAV_TICKS + 1);

  logic [3:0]       state, nxt;
  logic [CNT_W-1:0] cnt, period_m1;
  logic             grav_tick;
  logic [7:0]       lfsr, lfsr_next;
  logic [2:0]       spawn_type;

  function automatic logic [15:0] clear_points(input logic [2:0] n);
    case (n)
      3'd0:    clear_points = 16'd0;
      3'd1:    clear_points = 16'd40;
      3'd2:    clear_points = 16'd100;
      3'd3:    clear_points = 16'd300;
      default: clear_points = 16'd1200;
    endcase
  endfunction

  function automatic logic [15:0] sat_score(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_score = s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [9:0] sat_lines(input logic [9:0] a, input logic [2:0] n);
    logic [2:0]  m;
    logic [10:0] s;
    m = (n > 3'd4) ? 3'd4 : n;
    s = {1'b0, a} + {8'b0, m};
    sat_lines = (s > 11'd999) ? 10'd999 : s[9:0];
  endfunction

  assign period_m1  = (soft_drop ? CNT_W'(SOFT_TICKS) : CNT_W'(GRAV_TICKS)) - CNT_W'(1);
  assign grav_tick  = (cnt >= period_m1);
  assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign spawn_type = (lfsr_next[2:0] == 3'd7) ? 3'd0 : lfsr_next[2:0];

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:       if (start) nxt = S_SPAWN;
      S_SPAWN:      nxt = S_SPAWN_CHK;
      S_SPAWN_CHK:  if (bus.probe_done) nxt = bus.probe_hit ? S_GAME_OVER : S_FALL;
      S_FALL:       if (grav_tick) nxt = (ypos == 5'(BOTTOM_ROW)) ? S_LOCK : S_PROBE;
      S_PROBE:      if (bus.probe_done) nxt = bus.probe_hit ? S_LOCK : S_FALL;
      S_LOCK:       nxt = S_CLEAR;
      S_CLEAR:      nxt = S_CLEAR_WAIT;
      S_CLEAR_WAIT: if (bus.clear_done) nxt = S_SPAWN;
      S_GAME_OVER:  if (start) nxt = S_SPAWN;
      default:      nxt = S_IDLE;
    endcase
  end

  // Strobes and status flags are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      lfsr            <= LFSR_SEED;
      ypos            <= '0;
      block           <= '0;
      piece_active    <= 1'b0;
      score           <= '0;
      lines_total     <= '0;
      game_over       <= 1'b0;
      bus.probe_valid <= 1'b0;
      bus.probe_y     <= '0;
      bus.lock_en     <= 1'b0;
      bus.clear_start <= 1'b0;
    end else begin
      state           <= nxt;
      cnt             <= (state == S_FALL) ? cnt + CNT_W'(1) : '0;
      bus.probe_valid <= (nxt == S_SPAWN_CHK) || (nxt == S_PROBE);
      bus.lock_en     <= (nxt == S_LOCK);
      bus.clear_start <= (nxt == S_CLEAR);
      piece_active    <= (nxt == S_FALL) || (nxt == S_PROBE);
      game_over       <= (nxt == S_GAME_OVER);

      if (state == S_FALL && nxt == S_PROBE)
        bus.probe_y <= ypos + 5'd1;
      else if (nxt == S_SPAWN_CHK)
        bus.probe_y <= '0;

      case (state)
        S_SPAWN: begin
          lfsr  <= lfsr_next;
          block <= spawn_type;
          ypos  <= '0;
        end
        S_PROBE: begin
          if (bus.probe_done && !bus.probe_hit) ypos <= ypos + 5'd1;
        end
        S_CLEAR_WAIT: begin
          if (bus.clear_done) begin
            score       <= sat_score(score, clear_points(bus.lines_cleared));
            lines_total <= sat_lines(lines_total, bus.lines_cleared);
          end
        end
        S_GAME_OVER: begin
          if (start) begin
            score       <= '0;
            lines_total <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with short gravity periods.
module tb_game_sequencer;
  logic        pclk = 1'b0;
  logic        rst, start, soft_drop;
  logic [4:0]  ypos;
  logic [2:0]  block;
  logic        piece_active;
  logic [15:0] score;
  logic [9:0]  lines_total;
  logic        game_over;

  game_if gif();

  game_sequencer #(.GRAV_TICKS(8), .SOFT_TICKS(2)) dut (
    .pclk(pclk), .rst(rst), .start(start), .soft_drop(soft_drop), .bus(gif),
    .ypos(ypos), .block(block), .piece_active(piece_active), .score(score),
    .lines_total(lines_total), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  typedef struct packed { logic [2:0] lines; logic [15:0] score; logic [9:0] total; } vec_t;
  typedef struct packed { logic [15:0] score; logic [9:0] total; } exp_t;

  vec_t       vecs [7];
  exp_t       sb [$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] lfsr_m;
  int         m_score, m_lines;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  task automatic wait_probe(input string name, input int exp_n);
    int n = 0;
    while (!gif.probe_valid && n < 40) begin
      tick();
      n++;
    end
    if (exp_n >= 0) chk(name, 32'(n), 32'(exp_n));
    else            chk(name, 32'(gif.probe_valid), 1);
  endtask

  task automatic answer(input logic hit);
    gif.probe_done = 1'b1;
    gif.probe_hit  = hit;
    tick();
    gif.probe_done = 1'b0;
    gif.probe_hit  = 1'b0;
  endtask

  task automatic spawn_probe(input string name);
    logic [2:0] b;
    exp_t       e;
    wait_probe(name, -1);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    b = lfsr_m[2:0];
    if (b == 3'd7) b = 3'd0;
    chk({name, "_block"}, 32'(block), 32'(b));
    chk({name, "_probe_y"}, 32'(gif.probe_y), 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({name, "_score"}, 32'(score), 32'(e.score));
      chk({name, "_lines"}, 32'(lines_total), 32'(e.total));
    end
  endtask

  task automatic lock_clear(input logic [2:0] lines);
    int   n;
    exp_t e;
    chk("lock_en_high", 32'(gif.lock_en), 1);
    tick();
    chk("lock_en_single", 32'(gif.lock_en), 0);
    chk("clear_start_high", 32'(gif.clear_start), 1);
    tick();
    chk("clear_start_single", 32'(gif.clear_start), 0);
    gif.clear_done    = 1'b1;
    gif.lines_cleared = lines;
    n = (lines > 3'd4) ? 4 : int'(lines);
    m_score = m_score + pts(n);
    if (m_score > 65535) m_score = 65535;
    m_lines = m_lines + n;
    if (m_lines > 999) m_lines = 999;
    e.score = 16'(m_score);
    e.total = 10'(m_lines);
    sb.push_back(e);
    tick();
    gif.clear_done    = 1'b0;
    gif.lines_cleared = 3'd0;
  endtask

  task automatic play_piece(input logic [2:0] lines);
    answer(1'b0);
    wait_probe("soft_fall", 2);
    answer(1'b1);
    lock_clear(lines);
    spawn_probe("spawn");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    vecs[0] = '{3'd1, 16'd40,   10'd1};
    vecs[1] = '{3'd2, 16'd140,  10'd3};
    vecs[2] = '{3'd3, 16'd440,  10'd6};
    vecs[3] = '{3'd0, 16'd440,  10'd6};
    vecs[4] = '{3'd7, 16'd1640, 10'd10};
    vecs[5] = '{3'd5, 16'd2840, 10'd14};
    vecs[6] = '{3'd6, 16'd4040, 10'd18};

    rst = 1'b1; start = 1'b0; soft_drop = 1'b0;
    gif.probe_done = 1'b0; gif.probe_hit = 1'b0;
    gif.clear_done = 1'b0; gif.lines_cleared = 3'd0;
    lfsr_m = 8'hA5; m_score = 0; m_lines = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_ypos", 32'(ypos), 0);
    chk("rst_block", 32'(block), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_lines", 32'(lines_total), 0);
    chk("rst_probe_valid", 32'(gif.probe_valid), 0);
    chk("rst_game_over", 32'(game_over), 0);
    chk("rst_piece_active", 32'(piece_active), 0);
    chk("rst_lock_en", 32'(gif.lock_en), 0);
    chk("rst_clear_start", 32'(gif.clear_start), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("spawn_cycle_no_probe", 32'(gif.probe_valid), 0);
    tick();
    chk("spawn1_probe_valid", 32'(gif.probe_valid), 1);
    chk("spawn1_probe_y", 32'(gif.probe_y), 0);
    chk("spawn1_block", 32'(block), 2);
    lfsr_m = 8'h4A;
    answer(1'b0);
    chk("fall_piece_active", 32'(piece_active), 1);
    chk("fall_ypos", 32'(ypos), 0);
    chk("fall_probe_dropped", 32'(gif.probe_valid), 0);

    wait_probe("grav1_interval", 8);
    chk("grav1_probe_y", 32'(gif.probe_y), 1);
    answer(1'b0);
    chk("grav1_ypos", 32'(ypos), 1);
    wait_probe("grav2_interval", 8);
    answer(1'b0);
    chk("grav2_ypos", 32'(ypos), 2);
    wait_probe("grav3_interval", 8);
    repeat (20) tick();
    chk("held_probe_valid", 32'(gif.probe_valid), 1);
    chk("held_ypos", 32'(ypos), 2);
    answer(1'b0);
    chk("grav3_ypos", 32'(ypos), 3);

    soft_drop = 1'b1;
    wait_probe("soft_interval", 2);
    answer(1'b0);
    chk("soft_ypos", 32'(ypos), 4);
    soft_drop = 1'b0;
    wait_probe("soft_off_interval", 8);
    chk("soft_off_probe_y", 32'(gif.probe_y), 5);
    answer(1'b1);
    chk("lock_ypos_stable", 32'(ypos), 4);
    chk("lock_block_stable", 32'(block), 2);
    lock_clear(3'd4);
    chk("tetris_score", 32'(score), 1200);
    chk("tetris_lines", 32'(lines_total), 4);
    spawn_probe("spawn2");
    chk("spawn2_block_const", 32'(block), 5);

    soft_drop = 1'b1;
    answer(1'b0);
    for (int i = 0; i < 19; i++) begin
      wait_probe("drop_interval", 2);
      answer(1'b0);
    end
    chk("bottom_ypos", 32'(ypos), 19);
    gif.clear_done = 1'b1;
    gif.lines_cleared = 3'd4;
    tick();
    gif.clear_done = 1'b0;
    gif.lines_cleared = 3'd0;
    chk("stray_clear_score", 32'(score), 1200);
    chk("stray_clear_no_start", 32'(gif.clear_start), 0);
    chk("stray_clear_still_active", 32'(piece_active), 1);
    seen = 1'b0;
    n = 0;
    while (!gif.lock_en && n < 10) begin
      if (gif.probe_valid) seen = 1'b1;
      tick();
      n++;
    end
    chk("bottom_no_probe", 32'(seen), 0);
    lock_clear(3'd0);
    spawn_probe("spawn3");

    answer(1'b1);
    chk("go_flag", 32'(game_over), 1);
    chk("go_piece_active", 32'(piece_active), 0);
    chk("go_probe_valid", 32'(gif.probe_valid), 0);
    repeat (3) tick();
    chk("go_hold", 32'(game_over), 1);
    chk("go_ypos_hold", 32'(ypos), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_score", 32'(score), 0);
    chk("restart_lines", 32'(lines_total), 0);
    chk("restart_game_over", 32'(game_over), 0);
    m_score = 0;
    m_lines = 0;
    spawn_probe("restart_spawn");

    for (int i = 0; i < 7; i++) begin
      play_piece(vecs[i].lines);
      chk("vec_score", 32'(score), 32'(vecs[i].score));
      chk("vec_lines", 32'(lines_total), 32'(vecs[i].total));
    end
    for (int i = 0; i < 250; i++) play_piece(3'd4);
    chk("sat_score", 32'(score), 65535);
    chk("sat_lines", 32'(lines_total), 999);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    answer(1'b0);
    wait_probe("pre_rst_interval", 2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_probe_valid", 32'(gif.probe_valid), 0);
    chk("arst_ypos", 32'(ypos), 0);
    chk("arst_block", 32'(block), 0);
    chk("arst_score", 32'(score), 0);
    chk("arst_lines", 32'(lines_total), 0);
    chk("arst_piece_active", 32'(piece_active), 0);
    chk("arst_lock_en", 32'(gif.lock_en), 0);
    tick();
    rst = 1'b0;
    soft_drop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_block", 32'(block), 2);
    chk("post_rst_probe", 32'(gif.probe_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
